conv_stream_feeder: RTL
=======================

Name: conv_stream_feeder

Overview:
- Host-side transmitter for the convolution device's valid/ready operand interface.
- Reads weights and activations from an external word memory with a fixed 1-cycle read latency.
- Emits them as single-word beats in the exact order the device controller consumes them:
  - for each ch_in, then each ch_out: 2 weight beats;
  - then for each x, then each y: 2 activation beats.
- Sits between the testbench/host memory model and the device's data inputs. A 2-entry output FIFO keeps throughput at 1 beat/cycle under backpressure.

Parameters:
- FEATURE_MAP_WIDTH, 1024, x extent
- FEATURE_MAP_HEIGHT, 1024, y extent
- INPUT_NB_CHANNELS, 64, ch_in extent
- OUTPUT_NB_CHANNELS, 64, ch_out extent
- DATA_WIDTH, 16, beat/memory word width
- ADDR_WIDTH, 20, external memory address width
- WEIGHT_BASE, 0, word address of the first weight
- ACT_BASE, 'h40000, word address of the first activation

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- start  in  1  begin a stream; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last beat has been accepted
- mem_re  out  1  external read enable
- mem_addr  out  ADDR_WIDTH  external read address
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_re
- valid  out  1  beat available
- ready  in  1  device accepts the beat
- data  out  DATA_WIDTH  beat payload
- is_weight  out  1  current beat is a weight (debug/checker aid)

Behaviour:
- Clock and reset:
  - Clock clk; reset arst_n_in, asynchronous, active-low.
  - On reset: busy=0, done=0, mem_re=0, mem_addr=0, valid=0, data=0, is_weight=0, FIFO empty, all counters 0, state IDLE.
- Handshake:
  - A beat transfers on a clk edge where valid&&ready.
  - While valid&&!ready, data and is_weight are held stable.
  - valid never drops without a transfer.
- FIFO:
  - 2 entries, each holding {is_weight, data}.
  - Writes come from the read-return path: mem_re delayed 1 cycle, tagged with the delayed kind.
  - Reads occur on transfer.
  - valid = !empty; data/is_weight = head entry.
  - Simultaneous push and pop is allowed at any occupancy except push when full, which is prevented by credit.
- Credit rule: mem_re may assert only when (occupancy + reads_in_flight − pop_this_cycle) < 2. This guarantees no overflow with 0 combinational paths from mem_rdata to mem_re.
- FSM states and transitions:
  - IDLE: start → WGT, with all counters cleared and ptr_w=WEIGHT_BASE.
  - WGT: issues 2 weight reads (k=0,1) at ptr_w, ptr_w+1; ptr_w advances on each issue.
    - After k=1 issues → ACT, with ptr_a = ACT_BASE + ci*W*H*2.
    - ptr_a is maintained incrementally as row_base += W*H*2 on ci change; no multipliers.
  - ACT: issues 2 reads per (x,y); ptr_a increments each issue. Loop is y inner, x outer.
    - After (last_x, last_y, k=1): if last_co && last_ci → DRAIN; else → WGT, with co advancing (wrapping, and then ci advancing).
  - DRAIN: waits until FIFO empty and no read in flight → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Ordering: weight order is ci-major then co; weight address = WEIGHT_BASE + (ci*OUT+co)*2 + k. The same activation plane is re-streamed for each co.
- Totals: beats = IN*OUT*(2 + 2*W*H). Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Boundary cases:
  - start in non-IDLE states: ignored.
  - ready held low indefinitely: FSM stalls with ≤2 buffered + 0 in flight; no beat lost or duplicated.
  - ready high from the first beat: sustained 1 beat/cycle after a 2-cycle startup latency (start → first valid).
  - Reset mid-stream: immediate abort to the reset state; the next start restarts from beat 0.
  - Degenerate extents of 1 are legal (e.g. W=H=1 gives 4 beats per pair).

Decomposition:
- Package conv_feeder_pkg:
  - state enum {IDLE, WGT, ACT, DRAIN, DONE};
  - beat-kind constants;
  - function total_beats(W,H,IN,OUT).
- One sub-module: stream_fifo2, a parameterised-width 2-entry FIFO with push, pop, full, empty, count and async reset.

Test Plan:
- W=H=IN=OUT=2, ready=1 constant, mem model returns data=addr:
  - expect 40 beats, in order: WEIGHT_BASE+0, +1, then ACT_BASE+0..7, then WEIGHT_BASE+2, +3, then ACT_BASE+0..7, …;
  - done pulse exactly once; busy low the cycle after done.
- Same config, ready toggling pseudo-randomly at 30% high:
  - identical 40-beat sequence;
  - data stable whenever valid&&!ready;
  - FIFO never overflows (assertion).
- ready=0 for 50 cycles after start: mem_re issues exactly 2 reads, then stalls; releasing ready resumes with no gap >1 cycle.
- start pulsed again mid-stream: ignored; beat count still 40.
- arst_n_in asserted after beat 17: all outputs return to reset values asynchronously; a new start streams from WEIGHT_BASE+0.
- W=H=IN=OUT=1: 4 beats (W0, W1, A0, A1); start→first valid latency = 2 cycles; done 1 cycle after the last acceptance plus drain.

Source files
------------

// File: rtl/conv_feeder_pkg.sv
// Shared types and helpers for the convolution operand stream feeder.
package conv_feeder_pkg;
  typedef enum logic [2:0] {IDLE, WGT, ACT, DRAIN, DONE} state_e;

  localparam logic KIND_ACT = 1'b0;
  localparam logic KIND_WGT = 1'b1;

  function automatic int total_beats(int w, int h, int n_in, int n_out);
    return n_in * n_out * (2 + 2 * w * h);
  endfunction
endpackage

// File: rtl/conv_stream_feeder_if.sv
// Single-word valid/ready beat channel towards the convolution device.
interface conv_stream_feeder_if #(parameter int DATA_WIDTH = 16) ();
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  is_weight;

  modport master (output valid, data, is_weight, input ready);
  modport slave  (input valid, data, is_weight, output ready);
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry FIFO; head is always visible on rdata.
module stream_fifo2 #(parameter int WIDTH = 17) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);
  logic [1:0][WIDTH-1:0] mem;
  logic                  wp, rp;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mem   <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem[rp];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/conv_stream_feeder.sv
// Streams weights then activations from a 1-cycle-latency word memory as valid/ready beats.
module conv_stream_feeder
  import conv_feeder_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 20,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] ACT_BASE    = ADDR_WIDTH'('h40000)
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  conv_stream_feeder_if.master  beat
);
  localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int IW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
  localparam int OW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam logic [ADDR_WIDTH-1:0] PLANE =
    ADDR_WIDTH'(2 * FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT);

  state_e                state, nxt;
  logic                  k;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [IW-1:0]         ci;
  logic [OW-1:0]         co;
  logic [ADDR_WIDTH-1:0] ptr_w, ptr_a, row_base;
  logic                  rd_vld, rd_kind;
  logic                  push, pop, full, empty, credit_ok;
  logic [1:0]            fcnt;
  logic [DATA_WIDTH:0]   head;
  logic                  last_x, last_y, last_ci, last_co;

  assign last_x  = (x  == XW'(FEATURE_MAP_WIDTH  - 1));
  assign last_y  = (y  == YW'(FEATURE_MAP_HEIGHT - 1));
  assign last_ci = (ci == IW'(INPUT_NB_CHANNELS  - 1));
  assign last_co = (co == OW'(OUTPUT_NB_CHANNELS - 1));

  // Occupancy plus the read in flight, less this cycle's pop, must leave room.
  assign pop       = beat.valid & beat.ready;
  assign credit_ok = (({1'b0, fcnt} + {2'b0, rd_vld} - {2'b0, pop}) < 3'd2);
  assign push      = rd_vld;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state <= IDLE;
    else            state <= nxt;
  end

  always_comb begin
    nxt    = state;
    mem_re = 1'b0;
    done   = 1'b0;
    unique case (state)
      IDLE:  if (start) nxt = WGT;
      WGT:   if (credit_ok) begin
               mem_re = 1'b1;
               if (k) nxt = ACT;
             end
      ACT:   if (credit_ok) begin
               mem_re = 1'b1;
               if (k && last_x && last_y) nxt = (last_co && last_ci) ? DRAIN : WGT;
             end
      DRAIN: if (empty && !rd_vld) nxt = DONE;
      DONE:  begin
               done = 1'b1;
               nxt  = IDLE;
             end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      k        <= 1'b0;
      x        <= '0;
      y        <= '0;
      ci       <= '0;
      co       <= '0;
      ptr_w    <= '0;
      ptr_a    <= '0;
      row_base <= '0;
      rd_vld   <= 1'b0;
      rd_kind  <= KIND_ACT;
    end else begin
      rd_vld  <= mem_re;
      rd_kind <= (state == WGT) ? KIND_WGT : KIND_ACT;
      case (state)
        IDLE: if (start) begin
          k        <= 1'b0;
          x        <= '0;
          y        <= '0;
          ci       <= '0;
          co       <= '0;
          ptr_w    <= WEIGHT_BASE;
          ptr_a    <= ACT_BASE;
          row_base <= ACT_BASE;
        end
        WGT: if (mem_re) begin
          ptr_w <= ptr_w + 1'b1;
          k     <= ~k;
          if (k) ptr_a <= row_base;
        end
        ACT: if (mem_re) begin
          ptr_a <= ptr_a + 1'b1;
          k     <= ~k;
          if (k) begin
            y <= last_y ? '0 : y + 1'b1;
            if (last_y) x <= last_x ? '0 : x + 1'b1;
            // Plane repeats per ch_out; advance to the next plane only on ch_in change.
            if (last_x && last_y) begin
              co <= last_co ? '0 : co + 1'b1;
              if (last_co) begin
                ci       <= ci + 1'b1;
                row_base <= row_base + PLANE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = (state == ACT) ? ptr_a : ptr_w;
  assign busy     = (state != IDLE);

  stream_fifo2 #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (push),
    .wdata     ({rd_kind, mem_rdata}),
    .pop       (pop),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .count     (fcnt)
  );

  assign beat.valid = !empty;
  assign {beat.is_weight, beat.data} = head;

  always_ff @(posedge clk) begin
    if (arst_n_in) assert (!(push && full && !pop));
  end
endmodule
